data_mem_arbiter: RTL

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter in front of a single data memory.
// One transaction at a time runs IDLE -> BUSY (LATENCY cycles) -> DONE -> IDLE.
// The winner's request fields are latched at the IDLE edge and held on the
// memory side for the whole BUSY window. Load results are captured into the
// winner's rdata register on the edge that enters DONE.
//
// Optional feature: define ARB_RR_EN for round-robin on simultaneous requests.
// Without it, port 0 always wins a tie.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req0/1, wr0/1                 request (held until done), 1=store 0=load
//   addr0/1, wdata0/1             byte address, store data
//   grant0/1                      pulse in the first BUSY cycle of the port's transaction
//   done0/1                       pulse in the DONE cycle of the port's transaction
//   rdata0/1                      registered load results
//   mem_en, mem_wr, mem_addr,
//   mem_wdata, mem_rdata          data memory side, driven only in BUSY
//   busy                          high whenever the FSM is not IDLE
module data_mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        grant0,
  output logic        grant1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        id_q, id_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;
  logic        win;     // 1 = port 1 wins the IDLE arbitration
  logic        in_busy;

`ifdef ARB_RR_EN
  // Last-served pointer; resets to port 1 so port 0 wins the first tie.
  logic last_q, last_d;

  assign win    = (req0 && req1) ? ~last_q : ~req0;
  assign last_d = (state_q == IDLE && (req0 || req1)) ? win : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  assign win = ~req0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = BUSY;
          id_d    = win;
          wr_d    = win ? wr1    : wr0;
          addr_d  = win ? addr1  : addr0;
          wdata_d = win ? wdata1 : wdata0;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        // Last BUSY cycle: the memory has had LATENCY cycles, take the data.
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!wr_q) begin
            if (id_q) rdata1_d = mem_rdata;
            else      rdata0_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      id_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 16'h0;
      wdata_q  <= 16'h0;
      rdata0_q <= 16'h0;
      rdata1_q <= 16'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Outputs decode straight from state so reset clears them without a clock.
  assign in_busy   = (state_q == BUSY);
  assign busy      = (state_q != IDLE);
  // The counter only holds CNT_INIT in the first BUSY cycle (LATENCY >= 2).
  assign grant0    = in_busy && (cnt_q == CNT_INIT) && !id_q;
  assign grant1    = in_busy && (cnt_q == CNT_INIT) &&  id_q;
  assign done0     = (state_q == DONE) && !id_q;
  assign done1     = (state_q == DONE) &&  id_q;
  assign mem_en    = in_busy;
  assign mem_wr    = in_busy && wr_q;
  assign mem_addr  = in_busy ? addr_q  : 16'h0;
  assign mem_wdata = in_busy ? wdata_q : 16'h0;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule
